// File: rtl/mem_req_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the 2-port memory request arbiter.
//   arb_state_e  : FSM encoding (ST_IDLE, ST_GRANT)
//   NUM_PORTS    : number of requesters
//   PORT_ICACHE  : index of the icache refill requester
//   PORT_DATA    : index of the data/decompressor requester
package mem_arb_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int PORT_ICACHE = 0;
  localparam int PORT_DATA   = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side and memory-side signals of the arbiter.
//   req_valid/req_addr0/req_addr1 : requests from the two ports
//   req_ready/req_rdata           : completion pulse and read data back to the ports
//   mem_req_valid/mem_req_addr    : request to memory
//   mem_req_ready/mem_req_rdata   : memory completion pulse and read data
// Modports: slave = arbiter view, master = surrounding caches/memory view.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_rdata;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_req_rdata;

  modport slave (
    input  req_valid, req_addr0, req_addr1, mem_req_ready, mem_req_rdata,
    output req_ready, req_rdata, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr0, req_addr1, mem_req_ready, mem_req_rdata,
    input  req_ready, req_rdata, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/mem_req_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick.
//   i_req[1:0] : request vector
//   i_rr_ptr   : port favoured when both request
//   o_winner   : selected port (only meaningful when o_any is high)
//   o_any      : at least one request present
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_ptr,
  output logic       o_winner,
  output logic       o_any
);
  assign o_any = |i_req;

  always_comb begin
    o_winner = i_rr_ptr;
    if (i_req == 2'b01) o_winner = 1'b0;
    else if (i_req == 2'b10) o_winner = 1'b1;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one word-wide memory port between
// the icache refill path (port 0) and the data/decompressor fetch (port 1).
// A grant lasts exactly one memory beat; no data buffering, addresses pass through.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : requester and memory handshake signals
//   busy         : high while a grant is held
// Optional macro ARB_STATS_EN adds saturating counters stat_grants0/stat_grants1
// (completed beats per port) and stat_conflict (idle cycles with both requesting).
//
// state    | meaning
// ST_IDLE  | no grant; arbitrate among req_valid, memory ready ignored
// ST_GRANT | r_gnt owns the memory port until a ready pulse or the request drops
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  mem_req_arbiter_if.slave bus,
  output logic             busy
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_grants0,
  output logic [CNT_W-1:0] stat_grants1,
  output logic [CNT_W-1:0] stat_conflict
`endif
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_gnt, w_gnt_nxt;
  logic              r_rr_ptr, w_rr_nxt;
  logic              w_winner, w_any;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] w_rdata;

  rr_pick2 u_pick (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_addr_sel  = r_gnt ? bus.req_addr1 : bus.req_addr0;
  assign w_done      = (r_state == ST_GRANT) && bus.mem_req_ready;
  assign w_rdata     = bus.mem_req_rdata;
  assign bus.req_rdata = w_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Address is a don't-care while idle; holding the last one avoids needless toggling.
  always_ff @(posedge clk) begin
    if (r_state == ST_GRANT) r_last_addr <= w_addr_sel;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_winner;
        end
      end
      ST_GRANT: begin
        // Completion takes priority over a requester dropping in the same cycle.
        if (bus.mem_req_ready) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = ~r_gnt;
        end else if (!bus.req_valid[r_gnt]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy              = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = r_last_addr;
    bus.req_ready     = '0;
    if (r_state == ST_GRANT) begin
      busy              = 1'b1;
      bus.mem_req_valid = bus.req_valid[r_gnt];
      bus.mem_req_addr  = w_addr_sel;
      if (bus.mem_req_ready) begin
        if (r_gnt) bus.req_ready[PORT_DATA] = 1'b1;
        else       bus.req_ready[PORT_ICACHE] = 1'b1;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_grants0, r_grants1, r_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grants0  <= '0;
      r_grants1  <= '0;
      r_conflict <= '0;
    end else begin
      if (w_done && !r_gnt && !(&r_grants0)) r_grants0 <= r_grants0 + 1'b1;
      if (w_done && r_gnt && !(&r_grants1))  r_grants1 <= r_grants1 + 1'b1;
      if ((r_state == ST_IDLE) && (&bus.req_valid) && !(&r_conflict))
        r_conflict <= r_conflict + 1'b1;
    end
  end

  assign stat_grants0  = r_grants0;
  assign stat_grants1  = r_grants1;
  assign stat_conflict = r_conflict;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_STATS_EN
  localparam int CW = 3;
  localparam int CMAX = 7;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [CW-1:0] sg0, sg1, sc;
`endif

  mem_req_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef ARB_STATS_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_grants0  (sg0),
    .stat_grants1  (sg1),
    .stat_conflict (sc)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the port, whose turn it is on a tie, beat counts.
  bit          m_busy = 0;
  int          m_gnt  = 0;
  int          m_rr   = 0;
  logic [31:0] m_last_addr;
  bit          m_addr_known = 0;
  int          m_g0 = 0, m_g1 = 0, m_cf = 0;

  always @(posedge clk) begin
    if (m_busy) begin
      m_last_addr  = (m_gnt == 1) ? bus.req_addr1 : bus.req_addr0;
      m_addr_known = 1;
    end
    if (reset) begin
      m_busy = 0; m_rr = 0; m_g0 = 0; m_g1 = 0; m_cf = 0;
    end else if (!m_busy) begin
      if (bus.req_valid == 2'b11) m_cf++;
      if (bus.req_valid != 2'b00) begin
        m_busy = 1;
        if (bus.req_valid == 2'b11) m_gnt = m_rr;
        else m_gnt = bus.req_valid[1] ? 1 : 0;
      end
    end else begin
      if (bus.mem_req_ready) begin
        if (m_gnt == 0) m_g0++; else m_g1++;
        m_rr   = 1 - m_gnt;
        m_busy = 0;
      end else if (!bus.req_valid[m_gnt]) begin
        m_busy = 0;
      end
    end
  end

  logic [1:0]  log_rdy[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       exp_mv;
    exp_mv  = m_busy && bus.req_valid[m_gnt];
    exp_rdy = (m_busy && bus.mem_req_ready) ? ((m_gnt == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", busy, m_busy);
    chk("mem_req_valid", bus.mem_req_valid, exp_mv);
    chk("req_ready", bus.req_ready, exp_rdy);
    if (m_busy)
      chk("mem_req_addr", bus.mem_req_addr, (m_gnt == 1) ? bus.req_addr1 : bus.req_addr0);
    else if (m_addr_known)
      chk("mem_req_addr_hold", bus.mem_req_addr, m_last_addr);
    if (exp_rdy != 2'b00) chk("req_rdata", bus.req_rdata, bus.mem_req_rdata);
`ifdef ARB_STATS_EN
    chk("stat_grants0", sg0, (m_g0 > CMAX) ? CMAX : m_g0);
    chk("stat_grants1", sg1, (m_g1 > CMAX) ? CMAX : m_g1);
    chk("stat_conflict", sc, (m_cf > CMAX) ? CMAX : m_cf);
`endif
    if (bus.req_ready != 2'b00) begin
      log_rdy.push_back(bus.req_ready);
      log_addr.push_back(bus.mem_req_addr);
      log_data.push_back(bus.req_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mvalid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: mem_req_valid got 0 expected 1 within 40 cycles");
    end
  endtask

  // Memory answers `delay` cycles after it first sees a request.
  task automatic do_beat(input int delay, input logic [31:0] data);
    wait_mvalid();
    repeat (delay) tick();
    bus.mem_req_ready = 1'b1;
    bus.mem_req_rdata = data;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_req_rdata = '0;
  endtask

  logic [1:0]  e_rdy[4];
  logic [31:0] e_addr[4];
  int          base;

  initial begin
    reset             = 1'b1;
    bus.req_valid     = 2'b00;
    bus.req_addr0     = '0;
    bus.req_addr1     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_req_rdata = '0;

    // 1: idle after reset
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s1_mem_req_valid", bus.mem_req_valid, 1'b0);
      chk("s1_req_ready", bus.req_ready, 2'b00);
      chk("s1_busy", busy, 1'b0);
    end

    // 2: single port-0 beat
    tick();
    bus.req_addr0 = 32'h100;
    bus.req_addr1 = 32'h444;
    bus.req_valid = 2'b01;
    #1;
    chk("s2_arb_latency", bus.mem_req_valid, 1'b0);
    do_beat(3, 32'hDEADBEEF);
    bus.req_valid = 2'b00;
    chk("s2_beats", log_rdy.size(), 1);
    if (log_rdy.size() == 1) begin
      chk("s2_req_ready", log_rdy[0], 2'b01);
      chk("s2_addr", log_addr[0], 32'h100);
      chk("s2_rdata", log_data[0], 32'hDEADBEEF);
    end
    repeat (3) tick();

    // 3: both requesting from reset, four beats alternate
    reset = 1'b1;
    tick(); tick();
    bus.req_addr0 = 32'h200;
    bus.req_addr1 = 32'h800;
    bus.req_valid = 2'b11;
    reset = 1'b0;
    base = log_rdy.size();
    for (int i = 0; i < 4; i++) do_beat(1, 32'hA0 + i);
`ifdef ARB_STATS_EN
    chk("s3_stat_grants0", sg0, 2);
    chk("s3_stat_grants1", sg1, 2);
    chk("s3_conflict_nonzero", (sc >= 1), 1'b1);
`endif
    bus.req_valid = 2'b00;
    e_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    e_addr = '{32'h200, 32'h800, 32'h200, 32'h800};
    chk("s3_beats", log_rdy.size() - base, 4);
    if (log_rdy.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s3_order%0d", i), log_rdy[base+i], e_rdy[i]);
        chk($sformatf("s3_addr%0d", i), log_addr[base+i], e_addr[i]);
      end
    end
    tick();

    // 4: port 1 aborts, stray ready ignored, tie still goes to port 0
    bus.req_addr1 = 32'h840;
    bus.req_valid = 2'b10;
    wait_mvalid();
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("s4_mvalid_drop", bus.mem_req_valid, 1'b0);
    tick();
    chk("s4_idle", busy, 1'b0);
    bus.mem_req_ready = 1'b1;
    bus.mem_req_rdata = 32'h1234;
    #1;
    chk("s4_stray_ready", bus.req_ready, 2'b00);
    tick();
    bus.mem_req_ready = 1'b0;
    base = log_rdy.size();
    bus.req_valid = 2'b11;
    do_beat(1, 32'h55);
    bus.req_valid = 2'b00;
    chk("s4_beats", log_rdy.size() - base, 1);
    if (log_rdy.size() - base == 1) begin
      chk("s4_rr_kept", log_rdy[base], 2'b01);
      chk("s4_rr_addr", log_addr[base], 32'h200);
    end
    tick();

    // 5: reset mid-grant discards the beat and restores rr_ptr=0
    bus.req_addr0 = 32'h300;
    bus.req_addr1 = 32'h900;
    bus.req_valid = 2'b11;
    wait_mvalid();
    chk("s5_gnt1_addr", bus.mem_req_addr, 32'h900);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = log_rdy.size();
    bus.mem_req_ready = 1'b1;
    bus.mem_req_rdata = 32'hBAD;
    #1;
    chk("s5_no_ready", bus.req_ready, 2'b00);
    chk("s5_idle", busy, 1'b0);
    tick();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("s5_busy_again", busy, 1'b1);
    chk("s5_rr_reset", bus.mem_req_addr, 32'h300);
    chk("s5_no_beat", log_rdy.size() - base, 0);
    bus.req_valid = 2'b00;
    tick(); tick();

`ifdef ARB_STATS_EN
    // 6: counters saturate at all-ones
    bus.req_valid = 2'b11;
    for (int i = 0; i < 16; i++) do_beat(1, 32'hC0 + i);
    bus.req_valid = 2'b00;
    tick();
    chk("s6_sat_g0", sg0, CMAX);
    chk("s6_sat_g1", sg1, CMAX);
    chk("s6_sat_cf", sc, CMAX);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
